// File: rtl/ram_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_seq_if
// Description : CPU-side memory bus bundle for ram_seq. The core drives
//               address/data/request fields and the RAM returns read data,
//               the current MAR and the busy/done handshake.
//   master : addrs, addrs_we, data_in, mem_we, mem_rd, wide, inc (out)
//            data_out, mar, busy, done (in)
//   slave  : mirror of master
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0]   addrs;
    logic                addrs_we;
    logic [2*DATA_W-1:0] data_in;
    logic                mem_we;
    logic                mem_rd;
    logic                wide;
    logic                inc;
    logic [2*DATA_W-1:0] data_out;
    logic [ADDR_W-1:0]   mar;
    logic                busy;
    logic                done;

    modport master (
        output addrs, addrs_we, data_in, mem_we, mem_rd, wide, inc,
        input  data_out, mar, busy, done
    );

    modport slave (
        input  addrs, addrs_we, data_in, mem_we, mem_rd, wide, inc,
        output data_out, mar, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/ram_seq.sv
`default_nettype none
// ============================================================================
// Module      : ram_seq
// Description : Byte-lane RAM with a memory-address register (MAR) and a
//               sequencer that performs 1- or 2-lane (little-endian) accesses,
//               one lane per cycle, with optional MAR post-increment.
//   clk  : clock, all state changes on rising edge
//   rst  : synchronous active-high reset (aborts any access in flight)
//   bus  : ram_seq_if slave modport
//          in : addrs, addrs_we, data_in, mem_we, mem_rd, wide, inc
//          out: data_out, mar, busy, done
// Revision    : 1.0 - initial release
// ============================================================================
module ram_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    ram_seq_if.slave   bus
);

    localparam int                    c_state_w = 2;
    localparam logic [c_state_w-1:0]  c_idle    = 2'd0;
    localparam logic [c_state_w-1:0]  c_lane0   = 2'd1;
    localparam logic [c_state_w-1:0]  c_lane1   = 2'd2;
    localparam logic [ADDR_W-1:0]     c_step1   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0]     c_step2   = ADDR_W'(2);

    // Lane storage; contents are deliberately not reset.
    logic [DATA_W-1:0]    r_mem [0:(1<<ADDR_W)-1];

    logic [c_state_w-1:0] r_state;
    logic [c_state_w-1:0] w_state_nxt;

    // Access context captured at accept time.
    logic                 r_op_we;
    logic                 r_wide;
    logic                 r_inc;
    logic [2*DATA_W-1:0]  r_wdata;
    logic [ADDR_W-1:0]    r_addr;

    // Low lane of a wide read is staged so data_out only changes at completion.
    logic [DATA_W-1:0]    r_rd_lo;
    logic [2*DATA_W-1:0]  r_data_out;
    logic [ADDR_W-1:0]    r_mar;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_req;
    logic                 w_accept;
    logic                 w_lane_en;
    logic                 w_lane_hi;
    logic                 w_complete;
    logic [ADDR_W-1:0]    w_lane_addr;
    logic [DATA_W-1:0]    w_lane_rdata;

    assign w_req        = bus.mem_we | bus.mem_rd;
    assign w_lane_rdata = r_mem[w_lane_addr];

    // ------------------------------------------------------------------
    // Sequencer state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and lane control
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_lane_en   = 1'b0;
        w_lane_hi   = 1'b0;
        w_complete  = 1'b0;
        w_lane_addr = r_addr;
        case (r_state)
            c_idle: begin
                if (w_req) begin
                    w_accept    = 1'b1;
                    w_state_nxt = c_lane0;
                end
            end
            c_lane0: begin
                w_lane_en = 1'b1;
                if (r_wide) begin
                    w_state_nxt = c_lane1;
                end else begin
                    w_complete  = 1'b1;
                    w_state_nxt = c_idle;
                end
            end
            c_lane1: begin
                // High lane wraps naturally at the top of the address space.
                w_lane_en   = 1'b1;
                w_lane_hi   = 1'b1;
                w_lane_addr = r_addr + c_step1;
                w_complete  = 1'b1;
                w_state_nxt = c_idle;
            end
            default: begin
                w_state_nxt = c_idle;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Lane write port. Gated by rst so a reset landing on a lane edge
    // aborts that lane's write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_lane_en && r_op_we && !rst) begin
            r_mem[w_lane_addr] <= w_lane_hi ? r_wdata[2*DATA_W-1:DATA_W]
                                            : r_wdata[DATA_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Access context, MAR, read data and handshake
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op_we    <= 1'b0;
            r_wide     <= 1'b0;
            r_inc      <= 1'b0;
            r_wdata    <= '0;
            r_addr     <= '0;
            r_rd_lo    <= '0;
            r_data_out <= '0;
            r_mar      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != c_idle);
            r_done <= w_complete;

            if (w_accept) begin
                // Write wins when both requests are raised together.
                r_op_we <= bus.mem_we;
                r_wide  <= bus.wide;
                r_inc   <= bus.inc;
                r_wdata <= bus.data_in;
                r_addr  <= bus.addrs_we ? bus.addrs : r_mar;
            end

            // MAR loads only while idle; completion (never idle) may then
            // overwrite it with the post-incremented address.
            if ((r_state == c_idle) && bus.addrs_we) begin
                r_mar <= bus.addrs;
            end
            if (w_complete && r_inc) begin
                r_mar <= r_addr + (r_wide ? c_step2 : c_step1);
            end

            if (w_lane_en && !r_op_we) begin
                if (w_lane_hi) begin
                    r_data_out <= {w_lane_rdata, r_rd_lo};
                end else if (r_wide) begin
                    r_rd_lo <= w_lane_rdata;
                end else begin
                    r_data_out <= {{DATA_W{1'b0}}, w_lane_rdata};
                end
            end
        end
    end

    assign bus.data_out = r_data_out;
    assign bus.mar      = r_mar;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_seq
// Description : Self-checking bench for ram_seq. Directed scenarios followed
//               by randomized accesses compared against a byte-array model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_seq;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ram_seq_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: flat byte memory, MAR and last read result.
    logic [7:0]  m_mem [0:65535];
    logic [15:0] m_mar;
    logic [15:0] m_dout;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.addrs    = '0;
        bus.addrs_we = 1'b0;
        bus.data_in  = '0;
        bus.mem_we   = 1'b0;
        bus.mem_rd   = 1'b0;
        bus.wide     = 1'b0;
        bus.inc      = 1'b0;
    endtask

    // Issues one access at the current step point (DUT assumed idle), updates
    // the model, waits for done and checks latency, mar and data_out.
    task automatic access(input bit we, input bit rd, input bit wd, input bit in,
                          input bit load, input logic [15:0] addr,
                          input logic [15:0] din, input bit noise);
        logic [15:0] a;
        logic [15:0] a1;
        int          lat;
        bit          seen;
        a  = load ? addr : m_mar;
        a1 = a + 16'd1;
        bus.mem_we   = we;
        bus.mem_rd   = rd;
        bus.wide     = wd;
        bus.inc      = in;
        bus.addrs_we = load;
        bus.addrs    = addr;
        bus.data_in  = din;
        step();
        idle_inputs();

        if (load) m_mar = addr;
        if (we) begin
            m_mem[a] = din[7:0];
            if (wd) m_mem[a1] = din[15:8];
        end else begin
            m_dout = wd ? {m_mem[a1], m_mem[a]} : {8'h00, m_mem[a]};
        end
        if (in) m_mar = a + (wd ? 16'd2 : 16'd1);

        chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);

        seen = 1'b0;
        lat  = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            if (noise) begin
                bus.mem_we   = 1'($urandom);
                bus.mem_rd   = 1'b1;
                bus.addrs_we = 1'b1;
                bus.addrs    = 16'($urandom);
                bus.data_in  = 16'($urandom);
                bus.wide     = 1'($urandom);
                bus.inc      = 1'b1;
            end
            step();
            lat++;
            if (bus.done) seen = 1'b1;
        end
        idle_inputs();

        if (seen) chk("latency", lat, wd ? 32'd2 : 32'd1);
        else      chk("done_timeout", 32'd0, 32'd1);
        chk("busy_at_done", {31'd0, bus.busy}, 32'd0);
        chk("mar", {16'd0, bus.mar}, {16'd0, m_mar});
        chk("data_out", {16'd0, bus.data_out}, {16'd0, m_dout});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] off;
        logic [15:0] ra;
        bit          rwe;

        // Reset held two cycles with random inputs.
        rst          = 1'b1;
        bus.addrs    = 16'($urandom);
        bus.addrs_we = 1'($urandom);
        bus.data_in  = 16'($urandom);
        bus.mem_we   = 1'($urandom);
        bus.mem_rd   = 1'($urandom);
        bus.wide     = 1'($urandom);
        bus.inc      = 1'($urandom);
        step();
        step();
        chk("rst_mar",  {16'd0, bus.mar}, 32'd0);
        chk("rst_dout", {16'd0, bus.data_out}, 32'd0);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        rst = 1'b0;
        idle_inputs();
        m_mar  = 16'h0000;
        m_dout = 16'h0000;
        step();

        // Narrow write with post-increment, then narrow read back.
        access(1, 0, 0, 1, 1, 16'h1000, 16'h00AB, 0);
        chk("narrow_inc_mar", {16'd0, bus.mar}, 32'h1001);
        step();
        chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
        access(0, 1, 0, 0, 1, 16'h1000, 16'h0000, 0);
        chk("narrow_read", {16'd0, bus.data_out}, 32'h00AB);

        // Wide write / read, issued back-to-back on the done cycle.
        access(1, 0, 1, 0, 1, 16'h2000, 16'hBEEF, 0);
        access(0, 1, 1, 0, 1, 16'h2000, 16'h0000, 0);
        chk("wide_read", {16'd0, bus.data_out}, 32'hBEEF);
        access(0, 1, 0, 0, 1, 16'h2001, 16'h0000, 0);
        chk("wide_hi_lane", {16'd0, bus.data_out}, 32'h00BE);

        // Wrap at the top of the address space.
        access(1, 0, 1, 1, 1, 16'hFFFF, 16'h1234, 0);
        chk("wrap_mar", {16'd0, bus.mar}, 32'h0001);
        access(0, 1, 0, 0, 1, 16'hFFFF, 16'h0000, 0);
        chk("wrap_lo", {16'd0, bus.data_out}, 32'h0034);
        access(0, 1, 0, 0, 1, 16'h0000, 16'h0000, 0);
        chk("wrap_hi", {16'd0, bus.data_out}, 32'h0012);

        // Read and write together: write wins, data_out untouched.
        access(1, 1, 0, 0, 1, 16'h2100, 16'h0055, 0);
        chk("rdwe_dout_kept", {16'd0, bus.data_out}, 32'h0012);
        access(0, 1, 0, 0, 1, 16'h2100, 16'h0000, 0);
        chk("rdwe_written", {16'd0, bus.data_out}, 32'h0055);

        // Requests and MAR loads while busy are ignored.
        access(0, 1, 1, 0, 1, 16'h2000, 16'h0000, 1);
        chk("noise_mar", {16'd0, bus.mar}, 32'h2000);
        access(1, 0, 0, 0, 0, 16'h0000, 16'h00C3, 1);
        access(0, 1, 1, 0, 0, 16'h0000, 16'h0000, 0);
        chk("noise_mem", {16'd0, bus.data_out}, 32'hBEC3);
        step();

        // Reset during LANE1 of a wide write.
        access(1, 0, 0, 0, 1, 16'h3001, 16'h0077, 0);
        access(1, 0, 0, 0, 1, 16'h3000, 16'h0000, 0);
        bus.mem_we   = 1'b1;
        bus.wide     = 1'b1;
        bus.addrs_we = 1'b1;
        bus.addrs    = 16'h3000;
        bus.data_in  = 16'h5566;
        step();
        idle_inputs();
        step();
        chk("midrst_busy_before", {31'd0, bus.busy}, 32'd1);
        rst = 1'b1;
        step();
        chk("midrst_done", {31'd0, bus.done}, 32'd0);
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_mar",  {16'd0, bus.mar}, 32'd0);
        chk("midrst_dout", {16'd0, bus.data_out}, 32'd0);
        rst = 1'b0;
        m_mem[16'h3000] = 8'h66;
        m_mar  = 16'h0000;
        m_dout = 16'h0000;
        step();
        chk("midrst_no_late_done", {31'd0, bus.done}, 32'd0);
        access(0, 1, 1, 0, 1, 16'h3000, 16'h0000, 0);
        chk("midrst_mem", {16'd0, bus.data_out}, 32'h7766);

        // Randomized accesses in a window straddling the wrap point.
        for (int k = 0; k < 17; k++) begin
            access(1, 0, 0, 0, 1, 16'hFFF8 + 16'(k), 16'($urandom), 0);
        end
        for (int n = 0; n < 150; n++) begin
            ra  = 16'hFFF8 + 16'($urandom_range(0, 15));
            off = m_mar - 16'hFFF8;
            rwe = 1'($urandom);
            access(rwe, !rwe || 1'($urandom), 1'($urandom), 1'($urandom),
                   (off > 16'd15) || 1'($urandom), ra, 16'($urandom),
                   ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) begin
                step();
                chk("rand_done_pulse", {31'd0, bus.done}, 32'd0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
